// File: rtl/encap_pkg.sv
// rtl/encap_pkg.sv - per-set McEliece sizes, segment codes, FSM encoding and buffer payload for encap_result_reader
`timescale 1ns/1ps
package encap_pkg;

  function automatic int m_of(input int ps);
    int r;
    r = (ps == 1) ? 12 : 13;
    return r;
  endfunction

  function automatic int t_of(input int ps);
    int r;
    case (ps)
      1:       r = 64;
      2:       r = 96;
      3:       r = 128;
      4:       r = 119;
      default: r = 128;
    endcase
    return r;
  endfunction

  function automatic int l_of(input int ps);
    return m_of(ps) * t_of(ps);
  endfunction

  function automatic int c0_words_of(input int ps);
    return (l_of(ps) + 31) / 32;
  endfunction

  localparam logic [1:0] SEG_C0 = 2'd0;
  localparam logic [1:0] SEG_C1 = 2'd1;
  localparam logic [1:0] SEG_K  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_C0,
    S_RD_C1,
    S_RD_K,
    S_DRAIN,
    S_FIN
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  sel;
    logic        last;
  } rd_word_t;

endpackage

// File: rtl/encap_result_reader_if.sv
// rtl/encap_result_reader_if.sv - output word stream with valid/ready handshake
`timescale 1ns/1ps
interface encap_result_reader_if;
  logic [31:0] dout;
  logic [1:0]  dout_sel;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;

  modport master (output dout, dout_sel, dout_valid, dout_last, input dout_ready);
  modport slave  (input dout, dout_sel, dout_valid, dout_last, output dout_ready);
endinterface

// File: rtl/encap_rd_fifo2.sv
// rtl/encap_rd_fifo2.sv - 2-entry skid buffer holding returned words tagged with segment and last flag
`timescale 1ns/1ps
module encap_rd_fifo2
  import encap_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  rd_word_t push_word,
  input  logic     pop,
  output rd_word_t head,
  output logic [1:0] count
);

  rd_word_t mem [2];
  logic     wr_ptr;
  logic     rd_ptr;
  logic     do_push;
  logic     do_pop;

  // a push into a full buffer is only legal when the head leaves in the same cycle
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  // storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/encap_result_reader.sv
// rtl/encap_result_reader.sv - streams C0, C1 and K result memories as one word stream; ENCAP_RD_MASK_EN zeroes unused tail bits of the last C0 word
`timescale 1ns/1ps
module encap_result_reader
  import encap_pkg::*;
#(
  parameter  int parameter_set = 1,
  localparam int m        = m_of(parameter_set),
  localparam int t        = t_of(parameter_set),
  localparam int l        = m * t,
  localparam int C0_WORDS = (l + 31) / 32,
  localparam int AW       = $clog2(C0_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          rd_C0,
  output logic [AW-1:0] C0_addr,
  input  logic [31:0]   C0_out,
  output logic          rd_C1,
  output logic [2:0]    C1_addr,
  input  logic [31:0]   C1_out,
  output logic          rd_K,
  output logic [2:0]    K_addr,
  input  logic [31:0]   K_out,
  encap_result_reader_if.master strm,
  output logic          busy,
  output logic          done
);

  localparam int TAIL_BITS = l % 32;
  localparam logic [31:0] TAIL_MASK =
    (TAIL_BITS == 0) ? 32'hFFFF_FFFF : ((32'd1 << TAIL_BITS) - 32'd1);
  localparam logic [AW-1:0] C0_LAST = AW'(C0_WORDS - 1);
`ifdef ENCAP_RD_MASK_EN
  localparam bit TAIL_MASK_EN = 1'b1;
`else
  localparam bit TAIL_MASK_EN = 1'b0;
`endif

  state_t        state, state_nx;
  logic [AW-1:0] idx, idx_nx;
  logic          issue_last, issue_tail;
  logic          infl, infl_last, infl_tail;
  logic [1:0]    infl_sel;
  logic          pop, room;
  logic [2:0]    occupancy;
  logic [1:0]    count;
  rd_word_t      ret_word, head;

  // a slot leaving the buffer this cycle counts as free, giving 1 word/cycle under full flow
  assign pop       = strm.dout_valid && strm.dout_ready;
  assign occupancy = {1'b0, count} + {2'b0, infl} - {2'b0, pop};
  assign room      = (occupancy < 3'd2);

  assign C0_addr = idx;
  assign C1_addr = idx[2:0];
  assign K_addr  = idx[2:0];

  assign strm.dout       = head.data;
  assign strm.dout_sel   = head.sel;
  assign strm.dout_last  = head.last;
  assign strm.dout_valid = (count != 2'd0);

  assign busy = (state != S_IDLE);
  assign done = (state == S_FIN);

  // next state, read issue and address stepping
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    rd_C0      = 1'b0;
    rd_C1      = 1'b0;
    rd_K       = 1'b0;
    issue_last = 1'b0;
    issue_tail = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_RD_C0;
          idx_nx   = '0;
        end
      end
      S_RD_C0: begin
        if (room) begin
          rd_C0 = 1'b1;
          if (idx == C0_LAST) begin
            issue_tail = 1'b1;
            idx_nx     = '0;
            state_nx   = S_RD_C1;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      S_RD_C1: begin
        if (room) begin
          rd_C1 = 1'b1;
          if (idx[2:0] == 3'd7) begin
            idx_nx   = '0;
            state_nx = S_RD_K;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      S_RD_K: begin
        if (room) begin
          rd_K = 1'b1;
          if (idx[2:0] == 3'd7) begin
            issue_last = 1'b1;
            idx_nx     = '0;
            state_nx   = S_DRAIN;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (pop && head.last) begin
          state_nx = S_FIN;
        end
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // state, address and the tag of the read whose data returns next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      infl      <= 1'b0;
      infl_sel  <= SEG_C0;
      infl_last <= 1'b0;
      infl_tail <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      infl      <= rd_C0 | rd_C1 | rd_K;
      infl_sel  <= rd_C1 ? SEG_C1 : (rd_K ? SEG_K : SEG_C0);
      infl_last <= issue_last;
      infl_tail <= issue_tail;
    end
  end

  // select the returning memory and optionally clear bits beyond l in the last C0 word
  always_comb begin
    ret_word      = '0;
    ret_word.sel  = infl_sel;
    ret_word.last = infl_last;
    case (infl_sel)
      SEG_C1:  ret_word.data = C1_out;
      SEG_K:   ret_word.data = K_out;
      default: ret_word.data = C0_out;
    endcase
    if (TAIL_MASK_EN && infl_tail) begin
      ret_word.data = ret_word.data & TAIL_MASK;
    end
  end

  encap_rd_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (infl),
    .push_word (ret_word),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_encap_result_reader.sv
// tb/tb_encap_result_reader.sv - randomized scoreboard bench for encap_result_reader (sets 1 and 4)
`timescale 1ns/1ps
module tb_encap_result_reader;
  localparam int NW1 = 24;   // 12*64 bits
  localparam int NW4 = 49;   // 13*119 = 1547 bits
`ifdef ENCAP_RD_MASK_EN
  localparam logic [31:0] W48 = 32'h0000_07FF;
`else
  localparam logic [31:0] W48 = 32'hFFFF_FFFF;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic start, rd_C0, rd_C1, rd_K, busy, done;
  logic [4:0] C0_addr;
  logic [2:0] C1_addr, K_addr;
  logic [31:0] C0_out = '0, C1_out = '0, K_out = '0;
  encap_result_reader_if s1 ();

  logic start4, rd_C04, rd_C14, rd_K4, busy4, done4;
  logic [5:0] C0_addr4;
  logic [2:0] C1_addr4, K_addr4;
  logic [31:0] C0_out4 = '0, C1_out4 = '0, K_out4 = '0;
  encap_result_reader_if s4 ();

  encap_result_reader #(.parameter_set(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rd_C0(rd_C0), .C0_addr(C0_addr), .C0_out(C0_out),
    .rd_C1(rd_C1), .C1_addr(C1_addr), .C1_out(C1_out),
    .rd_K(rd_K), .K_addr(K_addr), .K_out(K_out),
    .strm(s1), .busy(busy), .done(done));

  encap_result_reader #(.parameter_set(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .rd_C0(rd_C04), .C0_addr(C0_addr4), .C0_out(C0_out4),
    .rd_C1(rd_C14), .C1_addr(C1_addr4), .C1_out(C1_out4),
    .rd_K(rd_K4), .K_addr(K_addr4), .K_out(K_out4),
    .strm(s4), .busy(busy4), .done(done4));

  logic [31:0] c0_mem [NW1];
  logic [31:0] c1_mem [8];
  logic [31:0] k_mem [8];

  always @(posedge clk) begin
    if (rd_C0) C0_out <= c0_mem[C0_addr];
    if (rd_C1) C1_out <= c1_mem[C1_addr];
    if (rd_K)  K_out  <= k_mem[K_addr];
    if (rd_C04) C0_out4 <= (C0_addr4 == 6'd48) ? 32'hFFFF_FFFF : {26'h0, C0_addr4};
    if (rd_C14) C1_out4 <= {16'h1, 13'h0, C1_addr4};
    if (rd_K4)  K_out4  <= {16'h2, 13'h0, K_addr4};
  end

  int total = 0;
  int bad = 0;
  logic [34:0] exp_q [$];
  int ready_mode = 0;
  int issued = 0, accepted = 0, run_words = 0, done_cnt = 0, done_cyc = 0, first_cyc = 0;
  bit arm_first = 0;
  logic [31:0] last_data = '0;
  int w4 = 0, done4_cnt = 0;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic logic [34:0] exp4(input int w);
    logic [31:0] d;
    logic [1:0] s;
    if (w < NW4) begin
      s = 2'd0;
      d = (w == 48) ? W48 : 32'(w);
    end else if (w < NW4 + 8) begin
      s = 2'd1;
      d = 32'h0001_0000 + 32'(w - NW4);
    end else begin
      s = 2'd2;
      d = 32'h0002_0000 + 32'(w - NW4 - 8);
    end
    return {(w == NW4 + 15), s, d};
  endfunction

  // ready driver
  initial begin
    s1.dout_ready = 1'b1;
    s4.dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: s1.dout_ready = 1'b1;
        1: s1.dout_ready = 1'($urandom_range(0, 1));
        default: s1.dout_ready = 1'b0;
      endcase
    end
  end

  // scoreboard monitor for the set-1 stream
  initial begin
    bit stalled;
    logic [34:0] held, cur;
    int nrd;
    stalled = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        issued = 0;
        accepted = 0;
        stalled = 0;
      end else begin
        cur = {s1.dout_last, s1.dout_sel, s1.dout};
        nrd = int'(rd_C0) + int'(rd_C1) + int'(rd_K);
        chk("rd_onehot", nrd <= 1, 64'(nrd), 64'd1);
        issued += nrd;
        if (s1.dout_valid && s1.dout_ready) accepted++;
        chk("outstanding", (issued - accepted) <= 2, 64'(issued - accepted), 64'd2);
        if (stalled) chk("hold", s1.dout_valid && (cur == held), {s1.dout_valid, cur}, {1'b1, held});
        if (s1.dout_valid && s1.dout_ready) begin
          chk("unexpected_word", exp_q.size() != 0, cur, 64'd0);
          if (exp_q.size() != 0) begin
            logic [34:0] e;
            e = exp_q.pop_front();
            chk("stream_word", cur == e, cur, e);
          end
          if (s1.dout_last) last_data = s1.dout;
          run_words++;
        end
        if (arm_first && s1.dout_valid) begin
          first_cyc = cyc;
          arm_first = 0;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        stalled = s1.dout_valid && !s1.dout_ready;
        held = cur;
      end
    end
  end

  // monitor for the set-4 stream
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (s4.dout_valid && s4.dout_ready) begin
          chk("set4_word", {s4.dout_last, s4.dout_sel, s4.dout} == exp4(w4),
              {s4.dout_last, s4.dout_sel, s4.dout}, exp4(w4));
          w4++;
        end
        if (done4) done4_cnt++;
      end
    end
  end

  task automatic load(input bit pattern);
    for (int i = 0; i < NW1; i++) begin
      c0_mem[i] = pattern ? 32'(i) : $urandom();
      exp_q.push_back({1'b0, 2'd0, c0_mem[i]});
    end
    for (int i = 0; i < 8; i++) begin
      c1_mem[i] = pattern ? (32'h0001_0000 + 32'(i)) : $urandom();
      exp_q.push_back({1'b0, 2'd1, c1_mem[i]});
    end
    for (int i = 0; i < 8; i++) begin
      k_mem[i] = pattern ? (32'h0002_0000 + 32'(i)) : $urandom();
      exp_q.push_back({(i == 7), 2'd2, k_mem[i]});
    end
  endtask

  task automatic pulse_start(output int sc);
    @(posedge clk);
    #1 start = 1'b1;
    sc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt > d0) begin
        ok = 1;
        break;
      end
    end
    chk(name, ok, 64'(done_cnt), 64'(d0 + 1));
  endtask

  task automatic wait_words(input int n, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (run_words >= n) begin
        ok = 1;
        break;
      end
    end
    chk("word_wait", ok, 64'(run_words), 64'(n));
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ctl"}, {rd_C0, rd_C1, rd_K, C0_addr, C1_addr, K_addr, busy, done} == '0,
        64'({rd_C0, rd_C1, rd_K, C0_addr, C1_addr, K_addr, busy, done}), 64'd0);
    chk({name, "_strm"}, {s1.dout, s1.dout_sel, s1.dout_valid, s1.dout_last} == '0,
        64'({s1.dout, s1.dout_sel, s1.dout_valid, s1.dout_last}), 64'd0);
    chk({name, "_set4"}, {rd_C04, C0_addr4, busy4, done4, s4.dout_valid, s4.dout} == '0,
        64'({rd_C04, C0_addr4, busy4, done4, s4.dout_valid, s4.dout}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, d0, is0;
    bit ok;
    start = 1'b0;
    start4 = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset_state");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // full flow, index pattern: timing and order
    ready_mode = 0;
    d0 = done_cnt;
    run_words = 0;
    load(1'b1);
    arm_first = 1;
    pulse_start(sc);
    wait_done("done_t1", d0, 200);
    chk("first_valid_cycle", first_cyc - sc == 3, 64'(first_cyc - sc), 64'd3);
    chk("done_cycle", done_cyc - sc == 43, 64'(done_cyc - sc), 64'd43);
    chk("last_word", last_data == 32'h0002_0007, 64'(last_data), 64'h0002_0007);
    chk("words_t1", run_words == 40, 64'(run_words), 64'd40);
    repeat (4) @(posedge clk);
    chk("single_done_t1", done_cnt == d0 + 1, 64'(done_cnt), 64'(d0 + 1));

    // set 4 tail masking
    w4 = 0;
    @(posedge clk);
    #1 start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (done4_cnt > 0) begin
        ok = 1;
        break;
      end
    end
    chk("set4_done", ok, 64'(done4_cnt), 64'd1);
    chk("set4_words", w4 == NW4 + 16, 64'(w4), 64'(NW4 + 16));

    // random data, random backpressure
    for (int r = 0; r < 3; r++) begin
      ready_mode = 1;
      d0 = done_cnt;
      run_words = 0;
      load(1'b0);
      pulse_start(sc);
      wait_done("done_rand", d0, 600);
      chk("drained_rand", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
      chk("words_rand", run_words == 40, 64'(run_words), 64'd40);
    end

    // stall 20 cycles at the first valid word
    ready_mode = 2;
    repeat (3) @(posedge clk);
    d0 = done_cnt;
    run_words = 0;
    load(1'b0);
    is0 = issued;
    arm_first = 1;
    pulse_start(sc);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (!arm_first) begin
        ok = 1;
        break;
      end
    end
    chk("stall_first_valid", ok, 64'(arm_first), 64'd0);
    repeat (20) @(posedge clk);
    chk("stall_reads", issued - is0 == 2, 64'(issued - is0), 64'd2);
    chk("stall_head", s1.dout_valid && s1.dout == c0_mem[0], {s1.dout_valid, s1.dout}, {1'b1, c0_mem[0]});
    ready_mode = 0;
    wait_done("done_stall", d0, 300);
    chk("drained_stall", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);

    // reset at word 10, then restart
    ready_mode = 1;
    run_words = 0;
    load(1'b0);
    pulse_start(sc);
    wait_words(10, 300);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_zero("mid_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    d0 = done_cnt;
    run_words = 0;
    load(1'b0);
    pulse_start(sc);
    wait_done("done_restart", d0, 600);
    chk("drained_restart", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
    chk("words_restart", run_words == 40, 64'(run_words), 64'd40);

    // start pulsed while busy is ignored
    ready_mode = 1;
    d0 = done_cnt;
    run_words = 0;
    load(1'b0);
    pulse_start(sc);
    wait_words(15, 300);
    pulse_start(sc);
    wait_done("done_restart_ignored", d0, 600);
    repeat (6) @(posedge clk);
    chk("single_done_busy_start", done_cnt == d0 + 1, 64'(done_cnt), 64'(d0 + 1));
    chk("drained_busy_start", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
    chk("words_busy_start", run_words == 40, 64'(run_words), 64'd40);
    chk("idle_after", !busy, 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
